// File: rtl/sd_data_sequencer_pkg.sv
// Shared definitions for the SD host data-path sequencer.
//   - Default widths for the block count and per-block timeout.
//   - Transfer direction constants.
//   - Sequencer state encoding.
//   - fifo_ready(): says whether the FIFO can serve the next block in the
//     latched direction.
package sd_data_sequencer_pkg;

    localparam int BLOCKS_W_DEF  = 8;
    localparam int TIMEOUT_W_DEF = 16;

    // Transfer direction: write is host->card (FIFO drained), read is card->host (FIFO filled)
    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FIFO = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_TRANSFER  = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } seq_state_e;

    // A write needs data waiting in the FIFO; a read needs room in it.
    function automatic logic fifo_ready(input logic dir, input logic empty, input logic full);
        return (dir == DIR_WRITE) ? !empty : !full;
    endfunction

endpackage

// File: rtl/sd_timeout_counter.sv
// Per-block timeout counter.
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  clear the count to zero (takes priority over en)
//   en      in  count one cycle; holds at all-ones instead of wrapping
//   cmp_en  in  qualifies the limit compare
//   limit   in  count value that flags a timeout
//   hit     out cmp_en and count == limit (combinational on the registered count)
module sd_timeout_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         cmp_en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign hit = cmp_en && (count == limit);

endmodule

// File: rtl/sd_data_sequencer.sv
// Block-level scheduler for the SD host data path. Latches one transfer
// command, then for each block waits for the FIFO, pulses oNewData to
// data_control and waits for the block to complete, under an optional
// per-block timeout.
//   iClock          in  single clock
//   iReset          in  synchronous active-high reset
//   iStart          in  command strobe (ignored while busy or with iAbort)
//   iAbort          in  host abort, highest priority outside IDLE
//   iWriteRead      in  1 = write (host->card), 0 = read
//   iMultipleData   in  1 = use iBlocks, 0 = single block
//   iBlocks         in  block count for multi-block commands
//   iTimeout_enable in  enable per-block timeout
//   iTimeout_reg    in  timeout limit in cycles
//   iFIFO_empty     in  FIFO empty flag
//   iFIFO_full      in  FIFO full flag
//   iBlock_done     in  block-complete pulse from data_control
//   oNewData        out pulse: start one block
//   oFIFO_clear     out pulse: flush FIFO on abort/timeout
//   oBusy           out command in progress
//   oDone           out pulse: all blocks completed
//   oTimeout        out pulse: block timed out
//   oBlocks_left    out remaining blocks
module sd_data_sequencer
    import sd_data_sequencer_pkg::*;
#(
    parameter int BLOCKS_W  = BLOCKS_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic                 iWriteRead,
    input  logic                 iMultipleData,
    input  logic [BLOCKS_W-1:0]  iBlocks,
    input  logic                 iTimeout_enable,
    input  logic [TIMEOUT_W-1:0] iTimeout_reg,
    input  logic                 iFIFO_empty,
    input  logic                 iFIFO_full,
    input  logic                 iBlock_done,
    output logic                 oNewData,
    output logic                 oFIFO_clear,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oTimeout,
    output logic [BLOCKS_W-1:0]  oBlocks_left
);

    // Command fields that matter after the start strobe. The single/multi
    // choice is folded into oBlocks_left at start and needs no storage.
    typedef struct packed {
        logic                 write_read;
        logic                 timeout_enable;
        logic [TIMEOUT_W-1:0] timeout_reg;
    } cmd_t;

    seq_state_e          state, state_d;
    cmd_t                cmd, cmd_d;
    logic [BLOCKS_W-1:0] blocks_left_d;
    logic [BLOCKS_W-1:0] start_count;
    logic                abort_hit;
    logic                fifo_ok;
    logic                to_clr, to_en, to_hit;
    logic                new_data_d, fifo_clear_d, busy_d, done_d, timeout_d;

    assign start_count = iMultipleData ? iBlocks : BLOCKS_W'(1);
    assign fifo_ok     = fifo_ready(cmd.write_read, iFIFO_empty, iFIFO_full);
    assign abort_hit   = iAbort && (state != ST_IDLE);

    // Count is zero in the first TRANSFER cycle, so a limit of N matches
    // in TRANSFER cycle N+1.
    assign to_clr = (state == ST_ISSUE);
    assign to_en  = (state == ST_TRANSFER);

    sd_timeout_counter #(
        .W (TIMEOUT_W)
    ) u_timeout (
        .clk    (iClock),
        .rst    (iReset),
        .clr    (to_clr),
        .en     (to_en),
        .cmp_en (cmd.timeout_enable),
        .limit  (cmd.timeout_reg),
        .hit    (to_hit)
    );

    // Next state, next command latch and next block count
    always_comb begin
        state_d       = state;
        cmd_d         = cmd;
        blocks_left_d = oBlocks_left;

        if (abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart && !iAbort) begin
                        cmd_d.write_read     = iWriteRead;
                        cmd_d.timeout_enable = iTimeout_enable;
                        cmd_d.timeout_reg    = iTimeout_reg;
                        blocks_left_d        = start_count;
                        state_d = (start_count == '0) ? ST_DONE : ST_WAIT_FIFO;
                    end
                end
                ST_WAIT_FIFO: begin
                    if (fifo_ok) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    state_d = ST_TRANSFER;
                end
                ST_TRANSFER: begin
                    // A completing block beats a timeout in the same cycle
                    if (iBlock_done) begin
                        blocks_left_d = oBlocks_left - BLOCKS_W'(1);
                        state_d = (oBlocks_left == BLOCKS_W'(1)) ? ST_DONE : ST_WAIT_FIFO;
                    end else if (to_hit) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERROR: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so each
    // pulse lines up with the state that owns it.
    always_comb begin
        new_data_d   = (state_d == ST_ISSUE);
        done_d       = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_ERROR);
        fifo_clear_d = (state_d == ST_ERROR) || abort_hit;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= ST_IDLE;
            cmd   <= '0;
        end else begin
            state <= state_d;
            cmd   <= cmd_d;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oBlocks_left <= '0;
            oNewData     <= 1'b0;
            oFIFO_clear  <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oTimeout     <= 1'b0;
        end else begin
            oBlocks_left <= blocks_left_d;
            oNewData     <= new_data_d;
            oFIFO_clear  <= fifo_clear_d;
            oBusy        <= busy_d;
            oDone        <= done_d;
            oTimeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sd_data_sequencer.sv
// Scoreboard bench for sd_data_sequencer. Each command is turned into the
// list of output events it must produce (new block, done, timeout+clear,
// abort clear), each with the block count that must be shown. A monitor
// pops one entry whenever any pulse output is high.
module tb_sd_data_sequencer;

    localparam int BW = 8;
    localparam int TW = 16;

    logic          iClock = 1'b0;
    logic          iReset, iStart, iAbort, iWriteRead, iMultipleData;
    logic [BW-1:0] iBlocks;
    logic          iTimeout_enable;
    logic [TW-1:0] iTimeout_reg;
    logic          iFIFO_empty, iFIFO_full, iBlock_done;
    logic          oNewData, oFIFO_clear, oBusy, oDone, oTimeout;
    logic [BW-1:0] oBlocks_left;

    sd_data_sequencer #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iStart          (iStart),
        .iAbort          (iAbort),
        .iWriteRead      (iWriteRead),
        .iMultipleData   (iMultipleData),
        .iBlocks         (iBlocks),
        .iTimeout_enable (iTimeout_enable),
        .iTimeout_reg    (iTimeout_reg),
        .iFIFO_empty     (iFIFO_empty),
        .iFIFO_full      (iFIFO_full),
        .iBlock_done     (iBlock_done),
        .oNewData        (oNewData),
        .oFIFO_clear     (oFIFO_clear),
        .oBusy           (oBusy),
        .oDone           (oDone),
        .oTimeout        (oTimeout),
        .oBlocks_left    (oBlocks_left)
    );

    always #5 iClock = ~iClock;

    // Event vector bits: {oNewData, oDone, oTimeout, oFIFO_clear}
    localparam logic [3:0] EV_NEW  = 4'b1000;
    localparam logic [3:0] EV_DONE = 4'b0100;
    localparam logic [3:0] EV_TO   = 4'b0011;
    localparam logic [3:0] EV_CLR  = 4'b0001;

    typedef struct packed {
        logic [3:0]    ev;
        logic [BW-1:0] bl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse cycle must match the next expected event
    initial begin
        forever begin
            @(negedge iClock);
            if ({oNewData, oDone, oTimeout, oFIFO_clear} != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {28'd0, oNewData, oDone, oTimeout, oFIFO_clear}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event", {28'd0, oNewData, oDone, oTimeout, oFIFO_clear}, {28'd0, mon_e.ev});
                    check("event_blocks_left", oBlocks_left, mon_e.bl);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drive FIFO flags; the flag the latched direction ignores is random
    task automatic set_ready(input bit wr, input bit rdy);
        if (wr) begin
            iFIFO_empty = !rdy;
            iFIFO_full  = 1'($urandom_range(0, 1));
        end else begin
            iFIFO_full  = !rdy;
            iFIFO_empty = 1'($urandom_range(0, 1));
        end
    endtask

    // Command inputs go random once the command is accepted
    task automatic scramble();
        iWriteRead      = 1'($urandom_range(0, 1));
        iMultipleData   = 1'($urandom_range(0, 1));
        iBlocks         = BW'($urandom);
        iTimeout_enable = 1'($urandom_range(0, 1));
        iTimeout_reg    = TW'($urandom_range(0, 3));
    endtask

    task automatic wait_newdata(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iClock);
            if (oNewData) begin
                seen = 1'b1;
                break;
            end
        end
        check("newdata_seen", {31'd0, seen}, 1);
    endtask

    // mode 0: all blocks complete; 1: timeout on block fail_blk;
    // 2: abort during block fail_blk. hold1 = FIFO wait before block index 1.
    // race puts iBlock_done on the cycle the limit is matched; poke
    // strobes iStart during TRANSFER.
    task automatic run_cmd(input bit wr, input bit multi, input int blocks, input bit to_en,
                           input int limit, input int mode, input int fail_blk,
                           input int hold1, input bit race, input bit poke);
        int n, w, j;
        bit seen;
        n = multi ? blocks : 1;
        for (int b = 0; b < n; b++) begin
            if (mode != 0 && b > fail_blk) break;
            exp_q.push_back('{ev: EV_NEW, bl: BW'(n - b)});
            if (mode == 1 && b == fail_blk) exp_q.push_back('{ev: EV_TO, bl: BW'(n - b)});
            if (mode == 2 && b == fail_blk) exp_q.push_back('{ev: EV_CLR, bl: BW'(n - b)});
        end
        if (mode == 0) exp_q.push_back('{ev: EV_DONE, bl: '0});

        set_ready(wr, 0);
        iWriteRead      = wr;
        iMultipleData   = multi;
        iBlocks         = BW'(blocks);
        iTimeout_enable = to_en;
        iTimeout_reg    = TW'(limit);
        iStart          = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        scramble();
        check("busy_after_start", {31'd0, oBusy}, 1);
        check("blocks_loaded", oBlocks_left, n);
        if (n == 0) begin
            @(negedge iClock);
            check("busy_after_empty", {31'd0, oBusy}, 0);
            return;
        end

        for (int b = 0; b < n; b++) begin
            w = (b == 1) ? hold1 : $urandom_range(0, 3);
            repeat (w) begin
                iBlock_done = 1'($urandom_range(0, 1));
                set_ready(wr, 0);
                @(negedge iClock);
                check("no_newdata_fifo_blocked", {31'd0, oNewData}, 0);
            end
            iBlock_done = 1'b0;
            set_ready(wr, 1);
            wait_newdata(seen);
            if (!seen) return;
            set_ready(wr, 0);

            if (mode == 1 && b == fail_blk) begin
                for (int k = 1; k <= limit + 1; k++) begin
                    @(negedge iClock);
                    check("no_early_timeout", {31'd0, oTimeout}, 0);
                end
                @(negedge iClock);
                check("timeout_pulse", {31'd0, oTimeout}, 1);
                check("timeout_clear", {31'd0, oFIFO_clear}, 1);
                @(negedge iClock);
                check("busy_after_timeout", {31'd0, oBusy}, 0);
                check("bl_after_timeout", oBlocks_left, n - b);
                return;
            end

            if (mode == 2 && b == fail_blk) begin
                repeat ($urandom_range(1, 3)) @(negedge iClock);
                iAbort = 1'b1;
                @(negedge iClock);
                iAbort = 1'b0;
                check("abort_busy", {31'd0, oBusy}, 0);
                check("abort_clear", {31'd0, oFIFO_clear}, 1);
                check("abort_bl", oBlocks_left, n - b);
                iBlock_done = 1'b1;
                @(negedge iClock);
                iBlock_done = 1'b0;
                repeat (2) @(negedge iClock);
                check("bl_after_stray_done", oBlocks_left, n - b);
                check("idle_after_stray_done", {31'd0, oBusy}, 0);
                return;
            end

            j = race ? limit + 1 : (to_en ? $urandom_range(1, limit + 1) : $urandom_range(1, 12));
            for (int k = 1; k <= j; k++) begin
                @(negedge iClock);
                iStart = poke && (k == 1);
            end
            iBlock_done = 1'b1;
            @(negedge iClock);
            iBlock_done = 1'b0;
            iStart      = 1'b0;
            check("bl_after_done", oBlocks_left, n - b - 1);
        end
        @(negedge iClock);
        check("busy_after_done", {31'd0, oBusy}, 0);
    endtask

    task automatic random_cmd();
        bit wr, multi, te;
        int blocks, limit, mode, fb, n;
        wr     = 1'($urandom_range(0, 1));
        multi  = 1'($urandom_range(0, 1));
        te     = 1'($urandom_range(0, 1));
        blocks = $urandom_range(0, 4);
        limit  = $urandom_range(3, 12);
        n      = multi ? blocks : 1;
        mode   = (n == 0) ? 0 : $urandom_range(0, 2);
        if (mode == 1) te = 1'b1;
        fb     = (n == 0) ? 0 : $urandom_range(0, n - 1);
        run_cmd(wr, multi, blocks, te, limit, mode, fb, $urandom_range(0, 3), 1'b0,
                1'($urandom_range(0, 1)));
    endtask

    initial begin
        iReset = 1'b1; iStart = 1'b0; iAbort = 1'b0; iBlock_done = 1'b0;
        iWriteRead = 1'b0; iMultipleData = 1'b0; iBlocks = '0;
        iTimeout_enable = 1'b0; iTimeout_reg = '0;
        iFIFO_empty = 1'b1; iFIFO_full = 1'b0;
        repeat (3) @(negedge iClock);
        check("rst_busy", {31'd0, oBusy}, 0);
        check("rst_pulses", {28'd0, oNewData, oDone, oTimeout, oFIFO_clear}, 0);
        check("rst_blocks_left", oBlocks_left, 0);
        iReset = 1'b0;
        @(negedge iClock);

        // Abort together with start in IDLE: nothing happens
        iAbort = 1'b1; iStart = 1'b1; iMultipleData = 1'b1; iBlocks = 8'd7; iWriteRead = 1'b1;
        iFIFO_empty = 1'b0;
        @(negedge iClock);
        iAbort = 1'b0; iStart = 1'b0;
        check("abort_start_idle_busy", {31'd0, oBusy}, 0);
        check("abort_start_idle_bl", oBlocks_left, 0);
        @(negedge iClock);
        check("abort_start_idle_busy2", {31'd0, oBusy}, 0);

        run_cmd(1, 0, 5, 0, 0,  0, 0, 0,  0, 0);  // single write, iBlocks ignored
        run_cmd(0, 1, 3, 0, 0,  0, 0, 10, 0, 0);  // multi read, FIFO full before block 2
        run_cmd(1, 1, 2, 1, 20, 1, 0, 0,  0, 0);  // timeout at limit 20
        run_cmd(0, 1, 3, 1, 15, 0, 0, 0,  1, 0);  // done on the limit cycle every block
        run_cmd(1, 1, 4, 0, 0,  2, 1, 0,  0, 0);  // abort in block 2 of 4
        run_cmd(0, 1, 0, 0, 0,  0, 0, 0,  0, 0);  // zero blocks
        run_cmd(1, 1, 2, 0, 0,  0, 0, 1,  0, 1);  // start while busy
        run_cmd(0, 0, 1, 1, 0,  1, 0, 0,  0, 0);  // limit 0 times out after one cycle

        // Reset mid-transfer
        set_ready(1, 1);
        iWriteRead = 1'b1; iMultipleData = 1'b1; iBlocks = 8'd4; iTimeout_enable = 1'b0;
        exp_q.push_back('{ev: EV_NEW, bl: 8'd4});
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        wait_newdata(ok);
        repeat (2) @(negedge iClock);
        iReset = 1'b1;
        exp_q.delete();
        @(negedge iClock);
        iReset = 1'b0;
        check("midrst_busy", {31'd0, oBusy}, 0);
        check("midrst_pulses", {28'd0, oNewData, oDone, oTimeout, oFIFO_clear}, 0);
        check("midrst_bl", oBlocks_left, 0);
        iBlock_done = 1'b1;
        @(negedge iClock);
        iBlock_done = 1'b0;
        @(negedge iClock);
        check("midrst_idle_bl", oBlocks_left, 0);

        for (int t = 0; t < 15; t++) random_cmd();

        repeat (3) @(negedge iClock);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
